// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NUM_REQ producers: round-robin grants with burst locking.
// Optional build macro FIFO_WR_ARB_PRIO_EN makes producer 0 win every arbitration.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          wclk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_valid;
  logic [IdW-1:0]        pick_id;
  logic [IdW-1:0]        cand;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  busy;
  logic                  wr_en;
  logic                  release_burst;
  logic [IdW-1:0]        next_ptr;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(rr_ptr_q) + k) % NUM_REQ);
`ifdef FIFO_WR_ARB_PRIO_EN
      if (!pick_valid && (cand != '0) && req_valid_i[cand]) begin
`else
      if (!pick_valid && req_valid_i[cand]) begin
`endif
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    if (req_valid_i[0]) begin
      pick_valid = 1'b1;
      pick_id    = '0;
    end
`endif
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IdW'(i)) begin
        owner_valid = req_valid_i[i];
        owner_last  = req_last_i[i];
        owner_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy          = (state_q == StBurst);
  assign wr_en         = busy & owner_valid & ~fifo_full_i;
  // req_last and the beat limit landing on the same write still release only once.
  assign release_burst = wr_en & (owner_last | (beat_cnt_q == CntW'(MAX_BURST - 1)));
  assign next_ptr      = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = busy & (grant_id_q == IdW'(i)) & ~fifo_full_i;
    end
  end

  assign fifo_wr_en_o   = wr_en;
  assign fifo_wr_data_o = owner_data;
  assign grant_id_o     = grant_id_q;
  assign busy_o         = busy;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        if (release_burst) begin
          state_d    = StIdle;
          beat_cnt_d = '0;
`ifdef FIFO_WR_ARB_PRIO_EN
          // High-priority grants leave the rotation among the others untouched.
          if (grant_id_q != '0) begin
            rr_ptr_d = next_ptr;
          end
`else
          rr_ptr_d = next_ptr;
`endif
        end else if (wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
